frenzy_input_ctrl: RTL and testbench
====================================

// Module: frenzy_input_ctrl
// PURPOSE
// Converts PS/2 key events and the two MiST joystick words into player-control levels for
// the frenzy core. Coin, start1 and start2 requests are arbitrated and sequenced by one shared
// pulse scheduler, so the core sees one fixed-width pulse at a time, each followed by a gap.
// Sits between user_io and the frenzy core, clocked in the core clock domain.
// PARAMETERS
// CNT_W      20      width of the pulse/gap counter
// PULSE_LEN  500000  high time of a coin/start pulse, in clocks (>=1, <2^CNT_W)
// GAP_LEN    500000  low time after each pulse before the next grant (>=1, <2^CNT_W)
// PORTS
// clock_10     in   1  core clock
// reset        in   1  asynchronous, active-high
// key_strobe   in   1  one-cycle key event valid
// key_pressed  in   1  1=make, 0=break (qualified by key_strobe)
// key_code     in   8  PS/2 set-2 code (qualified by key_strobe)
// joystick_0   in   8  [0]R [1]L [2]D [3]U [4]fire; other bits ignored
// joystick_1   in   8  same layout as joystick_0
// split        in   1  0: both joysticks OR'd into both players; 1: joy0->P1, joy1->P2
// up1,down1,left1,right1,fire1  out 1 each  player-1 controls
// up2,down2,left2,right2,fire2  out 1 each  player-2 controls
// coin1,start1,start2           out 1 each  sequenced pulses
// BEHAVIOUR
// - Reset: all outputs 0, key latches 0, request-edge history 0, pending flags 0,
//   FSM=IDLE, counter 0. Asynchronous assertion drops any pulse in progress immediately.
// - Key latches load key_pressed on the edge where key_strobe=1 and the code matches:
//   75 up, 72 down, 6B left, 74 right, 29 fire, 76 coin, 05 start1, 06 start2.
//   Other codes are ignored and leave all latches unchanged.
// - Key latches drive both players in either split mode.
// - Raw direction = key latch OR selected joystick bit(s).
// - Opposite-direction cleaning: up&down both raw-1 -> both outputs 0;
//   left&right both raw-1 -> both outputs 0.
// - Direction and fire outputs are registered and follow raw inputs 1 clock later.
//   A key strobe reaches the outputs 2 clocks after strobe sample (latch, then output reg).
// - Requests: coin = coin latch; s1 = start1 latch; s2 = start2 latch.
//   A rising edge (vs last cycle) sets that request's pending flag; levels held high do not
//   re-arm. At most one pending per source; further edges while pending are dropped.
// - Scheduler FSM:
//   IDLE: if any pending, grant the highest priority (coin > s1 > s2) and clear its
//         pending flag. Load counter=PULSE_LEN-1 and go to PULSE. Otherwise stay in IDLE.
//   PULSE: the granted output is 1, all other pulse outputs are 0. At counter 0, load
//          GAP_LEN-1 and go to GAP; otherwise decrement.
//   GAP: all pulse outputs 0. At counter 0, go to IDLE; otherwise decrement.
// - Pulse timing: the output rises on the clock after the grant and is high exactly
//   PULSE_LEN clocks. The earliest next rise is GAP_LEN+1 clocks after the fall
//   (GAP, then one IDLE grant cycle).
// - Simultaneous edge and grant of the same source: the set wins, pending stays 1, so a
//   second pulse follows.
// - Pending requests survive through PULSE/GAP; lower priorities wait and never preempt.
// - split changes take effect on the next output register update; no glitch filtering.
// TESTING (PULSE_LEN=4, GAP_LEN=3)
// 1. Strobe 75 make, then 72 make -> up1=1 two clocks after the first strobe; after the
//    second, up1=down1=0. Break 75 -> down1=1.
// 2. split=1, joystick_1=8'h10 -> fire2=1, fire1=0 next clock; split=0 -> fire1=1, fire2=1.
// 3. Coin make -> coin1 high exactly 4 clocks starting 2 clocks after the strobe;
//    hold make 100 clocks -> no second pulse.
// 4. Start1, start2 and coin edges in the same cycle -> coin1 (4 clocks), gap, then start1,
//    then start2. Rises are spaced 8 clocks apart; never two outputs high together.
// 5. Coin edge during coin1 PULSE (break then make) -> exactly one extra coin1 pulse after
//    the gap; a third edge during that PULSE while pending=1 is dropped.
// 6. Assert reset in clock 2 of a start1 pulse -> start1=0 immediately; after release,
//    FSM=IDLE with no pulses until a new edge. Unknown code 8'h1C strobe -> no change.

Source files
------------

// File: rtl/frenzy_input_ctrl_if.sv
// rtl/frenzy_input_ctrl_if.sv - key/joystick inputs and player-control outputs of frenzy_input_ctrl
interface frenzy_input_ctrl_if;
  logic       key_strobe;
  logic       key_pressed;
  logic [7:0] key_code;
  logic [7:0] joystick_0;
  logic [7:0] joystick_1;
  logic       split;
  logic       up1, down1, left1, right1, fire1;
  logic       up2, down2, left2, right2, fire2;
  logic       coin1, start1, start2;

  modport master (
    output key_strobe, key_pressed, key_code, joystick_0, joystick_1, split,
    input  up1, down1, left1, right1, fire1,
    input  up2, down2, left2, right2, fire2,
    input  coin1, start1, start2
  );

  modport slave (
    input  key_strobe, key_pressed, key_code, joystick_0, joystick_1, split,
    output up1, down1, left1, right1, fire1,
    output up2, down2, left2, right2, fire2,
    output coin1, start1, start2
  );
endinterface

// File: rtl/frenzy_input_ctrl.sv
// rtl/frenzy_input_ctrl.sv - PS/2 + joystick to frenzy player controls with a shared coin/start pulse scheduler
module frenzy_input_ctrl #(
  parameter int CNT_W     = 20,
  parameter int PULSE_LEN = 500000,
  parameter int GAP_LEN   = 500000
) (
  input  logic               clock_10,
  input  logic               reset,
  frenzy_input_ctrl_if.slave io
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Latch bits share the joystick layout: [0]R [1]L [2]D [3]U [4]fire, then [5]coin [6]s1 [7]s2
  logic [7:0] lat_q, lat_d;
  logic [2:0] rise;
  logic [4:0] sel1, sel2, p1_q, p2_q;
  logic [2:0] pend_q, pend_d, clr;
  logic [2:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       unused_joy_bits;

  assign unused_joy_bits = ^{io.joystick_0[7:5], io.joystick_1[7:5]};

  function automatic logic [4:0] clean(input logic [4:0] raw);
    logic [4:0] c;
    c = raw;
    if (raw[3] && raw[2]) c[3:2] = 2'b00;
    if (raw[1] && raw[0]) c[1:0] = 2'b00;
    return c;
  endfunction

  always_comb begin
    lat_d = lat_q;
    if (io.key_strobe) begin
      case (io.key_code)
        8'h74:   lat_d[0] = io.key_pressed;
        8'h6B:   lat_d[1] = io.key_pressed;
        8'h72:   lat_d[2] = io.key_pressed;
        8'h75:   lat_d[3] = io.key_pressed;
        8'h29:   lat_d[4] = io.key_pressed;
        8'h76:   lat_d[5] = io.key_pressed;
        8'h05:   lat_d[6] = io.key_pressed;
        8'h06:   lat_d[7] = io.key_pressed;
        default: ;
      endcase
    end
  end

  // Request edges are taken on the latch input so pending sets on the same edge as the latch
  assign rise = lat_d[7:5] & ~lat_q[7:5];

  assign sel1 = io.split ? io.joystick_0[4:0] : (io.joystick_0[4:0] | io.joystick_1[4:0]);
  assign sel2 = io.split ? io.joystick_1[4:0] : (io.joystick_0[4:0] | io.joystick_1[4:0]);

  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
    end else begin
      lat_q <= lat_d;
      p1_q  <= clean(sel1 | lat_q[4:0]);
      p2_q  <= clean(sel2 | lat_q[4:0]);
    end
  end

  assign io.right1 = p1_q[0];
  assign io.left1  = p1_q[1];
  assign io.down1  = p1_q[2];
  assign io.up1    = p1_q[3];
  assign io.fire1  = p1_q[4];
  assign io.right2 = p2_q[0];
  assign io.left2  = p2_q[1];
  assign io.down2  = p2_q[2];
  assign io.up2    = p2_q[3];
  assign io.fire2  = p2_q[4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    clr     = 3'b000;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          if (pend_q[0])      grant_d = 3'b001;
          else if (pend_q[1]) grant_d = 3'b010;
          else                grant_d = 3'b100;
          clr     = grant_d;
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the source being granted wins over the clear, queueing one more pulse
  assign pend_d = (pend_q & ~clr) | rise;

  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
    end
  end

  assign io.coin1  = (state_q == PULSE) && grant_q[0];
  assign io.start1 = (state_q == PULSE) && grant_q[1];
  assign io.start2 = (state_q == PULSE) && grant_q[2];

endmodule

// File: tb/tb_frenzy_input_ctrl.sv
// tb/tb_frenzy_input_ctrl.sv - directed vector bench for frenzy_input_ctrl
module tb_frenzy_input_ctrl;
  logic clock_10 = 1'b0;
  logic reset;

  frenzy_input_ctrl_if io();

  frenzy_input_ctrl #(.CNT_W(20), .PULSE_LEN(4), .GAP_LEN(3)) dut (
    .clock_10 (clock_10),
    .reset    (reset),
    .io       (io)
  );

  always #5 clock_10 = ~clock_10;

  typedef struct {
    logic       split;
    logic [7:0] j0;
    logic [7:0] j1;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[10];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] trace[256];
  logic [2:0] expt[256];
  int         tr_n = 0;
  bit         rec = 0;
  int         overlap = 0;

  // {up1,down1,left1,right1,fire1,up2,down2,left2,right2,fire2}
  function automatic logic [9:0] dirs();
    return {io.up1, io.down1, io.left1, io.right1, io.fire1,
            io.up2, io.down2, io.left2, io.right2, io.fire2};
  endfunction

  function automatic logic [2:0] pulses();
    return {io.coin1, io.start1, io.start2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_10);
    #1;
    if (rec && tr_n < 256) begin
      trace[tr_n] = pulses();
      tr_n++;
    end
    if ($countones(pulses()) > 1) overlap++;
  endtask

  task automatic key(input logic [7:0] c, input logic p);
    io.key_code    = c;
    io.key_pressed = p;
    io.key_strobe  = 1'b1;
    step();
    io.key_strobe  = 1'b0;
    io.key_code    = 8'h00;
    io.key_pressed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic start_rec();
    for (int i = 0; i < 256; i++) expt[i] = 3'b000;
    tr_n = 0;
    rec  = 1'b1;
  endtask

  // bitpos: 2=coin1, 1=start1, 0=start2; pulse is 4 samples long
  task automatic add_pulse(input int bitpos, input int s);
    for (int i = s; i < s + 4; i++) expt[i][bitpos] = 1'b1;
  endtask

  task automatic check_trace(input string name, input int n);
    int bad;
    bad  = -1;
    rec  = 1'b0;
    checks++;
    if (tr_n < n) begin
      failures++;
      $display("FAIL %s samples got=%0d want=%0d", name, tr_n, n);
    end else begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && trace[i] !== expt[i]) bad = i;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%b want=%b", name, bad, trace[bad], expt[bad]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h00, 10'b00000_00000};
    vecs[1] = '{1'b1, 8'h00, 8'h10, 10'b00000_00001};
    vecs[2] = '{1'b0, 8'h00, 8'h10, 10'b00001_00001};
    vecs[3] = '{1'b1, 8'h08, 8'h04, 10'b10000_01000};
    vecs[4] = '{1'b0, 8'h08, 8'h04, 10'b00000_00000};
    vecs[5] = '{1'b1, 8'h03, 8'h02, 10'b00000_00100};
    vecs[6] = '{1'b0, 8'h01, 8'h00, 10'b00010_00010};
    vecs[7] = '{1'b1, 8'h1F, 8'hE0, 10'b00001_00000};
    vecs[8] = '{1'b0, 8'hE0, 8'h00, 10'b00000_00000};
    vecs[9] = '{1'b1, 8'h14, 8'h09, 10'b01001_10010};

    io.key_strobe  = 1'b0;
    io.key_pressed = 1'b0;
    io.key_code    = 8'h00;
    io.joystick_0  = 8'h00;
    io.joystick_1  = 8'h00;
    io.split       = 1'b0;
    reset          = 1'b1;
    idle(3);
    chk("reset_dirs", 32'(dirs()), 32'h0);
    chk("reset_pulses", 32'(pulses()), 32'h0);
    reset = 1'b0;
    idle(2);
    chk("post_reset_dirs", 32'(dirs()), 32'h0);

    for (int i = 0; i < 10; i++) begin
      io.split      = vecs[i].split;
      io.joystick_0 = vecs[i].j0;
      io.joystick_1 = vecs[i].j1;
      step();
      chk($sformatf("vec%0d", i), 32'(dirs()), 32'(vecs[i].exp));
    end
    io.split      = 1'b0;
    io.joystick_0 = 8'h00;
    io.joystick_1 = 8'h00;
    idle(2);

    key(8'h75, 1'b1);
    chk("up_latency", 32'(dirs()), 32'h0);
    step();
    chk("up_make", 32'(dirs()), 32'(10'b10000_10000));
    key(8'h72, 1'b1);
    step();
    chk("updown_cancel", 32'(dirs()), 32'h0);
    key(8'h75, 1'b0);
    step();
    chk("down_only", 32'(dirs()), 32'(10'b01000_01000));
    key(8'h72, 1'b0);
    step();
    chk("keys_released", 32'(dirs()), 32'h0);

    start_rec();
    key(8'h76, 1'b1);
    idle(104);
    add_pulse(2, 1);
    check_trace("coin_hold", 105);
    key(8'h76, 1'b0);
    idle(10);

    start_rec();
    key(8'h06, 1'b1);
    key(8'h06, 1'b0);
    key(8'h05, 1'b1);
    key(8'h76, 1'b1);
    key(8'h06, 1'b1);
    idle(36);
    add_pulse(0, 1);
    add_pulse(2, 9);
    add_pulse(1, 17);
    add_pulse(0, 25);
    check_trace("priority_order", 41);
    key(8'h05, 1'b0);
    key(8'h76, 1'b0);
    key(8'h06, 1'b0);
    idle(10);

    start_rec();
    key(8'h76, 1'b1);
    key(8'h76, 1'b0);
    key(8'h76, 1'b1);
    key(8'h76, 1'b0);
    key(8'h76, 1'b1);
    idle(36);
    add_pulse(2, 1);
    add_pulse(2, 9);
    check_trace("coin_repend_drop", 41);
    key(8'h76, 1'b0);
    idle(12);

    start_rec();
    key(8'h76, 1'b1);
    key(8'h76, 1'b0);
    key(8'h76, 1'b1);
    idle(5);
    key(8'h76, 1'b0);
    key(8'h76, 1'b1);
    idle(31);
    add_pulse(2, 1);
    add_pulse(2, 9);
    add_pulse(2, 17);
    check_trace("coin_set_wins", 41);
    key(8'h76, 1'b0);
    idle(12);

    key(8'h05, 1'b1);
    step();
    chk("start1_pulse_up", 32'(pulses()), 32'h2);
    step();
    reset = 1'b1;
    #1;
    chk("start1_async_drop", 32'(pulses()), 32'h0);
    step();
    reset = 1'b0;
    start_rec();
    idle(20);
    check_trace("no_pulse_after_reset", 20);

    key(8'h75, 1'b1);
    step();
    chk("up_after_reset", 32'(dirs()), 32'(10'b10000_10000));
    key(8'h1C, 1'b1);
    key(8'h1C, 1'b0);
    step();
    chk("unknown_code_dirs", 32'(dirs()), 32'(10'b10000_10000));
    chk("unknown_code_pulses", 32'(pulses()), 32'h0);

    chk("no_overlap", 32'(overlap), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
